// File: rtl/rs_pkg.sv
// Shared constants and types for the RS(255,239) correction back-end sequencer.
package rs_pkg;
    localparam int N         = 255;
    localparam int K         = 239;
    localparam int T         = 8;
    localparam int M         = 8;
    localparam int CHIEN_LAT = 14;
    localparam int OUT_LAT   = 2;
    localparam int NUM_BANKS = 2;
    localparam int LAT_CYC   = CHIEN_LAT - OUT_LAT;

    localparam logic [M-1:0] LAST_ADDR = M'(N - 1);

    typedef enum logic [2:0] {IDLE, WAIT_KES, START, LAT, READ} rd_state_t;

    typedef struct packed {
        logic sof;
        logic eof;
        logic fail;
    } out_tag_t;

    function automatic logic is_fail(input logic [3:0] deg);
        return deg > 4'(T);
    endfunction
endpackage

// File: rtl/rs_frame_sequencer_if.sv
// Symbol-input, KES, buffer and output-framing signals of the frame sequencer.
interface rs_frame_sequencer_if;
    import rs_pkg::*;

    logic         in_valid;
    logic         in_sof;
    logic         kes_done;
    logic [3:0]   err_deg;
    logic         buf_wr_en;
    logic         buf_wr_bank;
    logic [M-1:0] buf_wr_addr;
    logic         chien_start;
    logic         buf_rd_en;
    logic         buf_rd_bank;
    logic [M-1:0] buf_rd_addr;
    logic         out_valid;
    logic         out_sof;
    logic         out_eof;
    logic         decode_fail;
    logic         frame_drop;
    logic         busy;

    modport master (
        output in_valid, in_sof, kes_done, err_deg,
        input  buf_wr_en, buf_wr_bank, buf_wr_addr, chien_start,
        input  buf_rd_en, buf_rd_bank, buf_rd_addr,
        input  out_valid, out_sof, out_eof, decode_fail, frame_drop, busy
    );

    modport slave (
        input  in_valid, in_sof, kes_done, err_deg,
        output buf_wr_en, buf_wr_bank, buf_wr_addr, chien_start,
        output buf_rd_en, buf_rd_bank, buf_rd_addr,
        output out_valid, out_sof, out_eof, decode_fail, frame_drop, busy
    );
endinterface

// File: rtl/rs_bank_tracker.sv
// Write-side bookkeeping for the ping-pong buffer: write counter, write bank,
// per-bank full flags and the oldest-full-bank pointer used by the reader.
module rs_bank_tracker
    import rs_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_sof,
    input  logic                 rel,
    output logic                 wr_en,
    output logic                 wr_bank,
    output logic [M-1:0]         wr_addr,
    output logic                 wr_done,
    output logic [NUM_BANKS-1:0] full,
    output logic                 rd_bank,
    output logic                 frame_drop
);
    logic                 wr_active;
    logic [M-1:0]         wr_cnt;
    logic                 sof_ok;
    logic                 drop;
    logic [NUM_BANKS-1:0] full_n;

    // Banks fill and drain in strict alternation, so a full write bank means both are full.
    assign sof_ok  = in_valid & in_sof & ~full[wr_bank];
    assign drop    = in_valid & in_sof & full[wr_bank];
    assign wr_en   = sof_ok | (in_valid & wr_active);
    assign wr_addr = sof_ok ? '0 : wr_cnt;
    assign wr_done = in_valid & ~in_sof & wr_active & (wr_cnt == LAST_ADDR);

    // Release and fill always target different banks, so both can land in one cycle.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign full_n[b] = (full[b] & ~(rel & (rd_bank == 1'(b))))
                         | (wr_done & (wr_bank == 1'(b)));
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wr_active  <= 1'b0;
            wr_bank    <= 1'b0;
            wr_cnt     <= '0;
            full       <= '0;
            rd_bank    <= 1'b0;
            frame_drop <= 1'b0;
        end else begin
            full       <= full_n;
            frame_drop <= drop;
            if (rel) rd_bank <= ~rd_bank;
            if (sof_ok) begin
                wr_active <= 1'b1;
                wr_cnt    <= M'(1);
            end else if (wr_done) begin
                wr_active <= 1'b0;
                wr_cnt    <= '0;
                wr_bank   <= ~wr_bank;
            end else if (in_valid & wr_active) begin
                wr_cnt <= wr_cnt + M'(1);
            end
        end
    end
endmodule

// File: rtl/rs_frame_sequencer.sv
// Frame scheduler for the RS(255,239) back end: ping-pong buffer control,
// Chien start / correction-window sequencing and SOF/EOF output framing.
module rs_frame_sequencer
    import rs_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 rst_n,
    rs_frame_sequencer_if.slave  bus
);
    logic [NUM_BANKS-1:0] full;
    logic                 rd_ptr;
    logic                 wr_done;
    logic                 rel;

    rd_state_t            state;
    logic [M-1:0]         lat_cnt;
    logic                 fail;
    logic                 chien_start;
    logic                 rd_en;
    logic                 rd_bank;
    logic [M-1:0]         rd_addr;

    out_tag_t                 tag_in;
    logic [OUT_LAT-1:0]       vld_pipe;
    out_tag_t [OUT_LAT-1:0]   tag_pipe;

    rs_bank_tracker u_trk (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .in_valid   (bus.in_valid),
        .in_sof     (bus.in_sof),
        .rel        (rel),
        .wr_en      (bus.buf_wr_en),
        .wr_bank    (bus.buf_wr_bank),
        .wr_addr    (bus.buf_wr_addr),
        .wr_done    (wr_done),
        .full       (full),
        .rd_bank    (rd_ptr),
        .frame_drop (bus.frame_drop)
    );

    assign rel = (state == READ) & (rd_addr == LAST_ADDR);

    // buf_rd_en rises LAT_CYC cycles after chien_start so data_out lines up with
    // the first Chien error value, CHIEN_LAT cycles after the start pulse.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            fail        <= 1'b0;
            chien_start <= 1'b0;
            rd_en       <= 1'b0;
            rd_bank     <= 1'b0;
            rd_addr     <= '0;
        end else begin
            chien_start <= 1'b0;
            case (state)
                IDLE: if (|full) state <= WAIT_KES;
                WAIT_KES: if (bus.kes_done) begin
                    fail        <= is_fail(bus.err_deg);
                    chien_start <= 1'b1;
                    state       <= START;
                end
                START: begin
                    lat_cnt <= '0;
                    state   <= LAT;
                end
                LAT: begin
                    if (lat_cnt == M'(LAT_CYC - 2)) begin
                        rd_en   <= 1'b1;
                        rd_addr <= '0;
                        rd_bank <= rd_ptr;
                        state   <= READ;
                    end else begin
                        lat_cnt <= lat_cnt + M'(1);
                    end
                end
                READ: begin
                    if (rd_addr == LAST_ADDR) begin
                        rd_en   <= 1'b0;
                        rd_addr <= '0;
                        state   <= (full[~rd_ptr] | wr_done) ? WAIT_KES : IDLE;
                    end else begin
                        rd_addr <= rd_addr + M'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tag_in.sof  = rd_en & (rd_addr == '0);
    assign tag_in.eof  = rd_en & (rd_addr == LAST_ADDR);
    assign tag_in.fail = rd_en & fail;

    // RAM read plus correct register: framing tags travel alongside the valid bit.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else begin
            vld_pipe[0] <= rd_en;
            tag_pipe[0] <= tag_in;
            for (int i = 1; i < OUT_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign bus.chien_start = chien_start;
    assign bus.buf_rd_en   = rd_en;
    assign bus.buf_rd_bank = rd_bank;
    assign bus.buf_rd_addr = rd_addr;
    assign bus.out_valid   = vld_pipe[OUT_LAT-1];
    assign bus.out_sof     = tag_pipe[OUT_LAT-1].sof;
    assign bus.out_eof     = tag_pipe[OUT_LAT-1].eof;
    assign bus.decode_fail = tag_pipe[OUT_LAT-1].fail;
    assign bus.busy        = (|full) | (state != IDLE);
endmodule
